// File: rtl/data_ram_arbiter.sv
// Two-master arbiter for the single-port data RAM.
// Master 0 is the core LSU, master 1 is the AXI-to-memory bridge. Grants are combinational,
// ties are broken round-robin, and one response per grant comes back exactly one cycle later.
// Accesses outside the RAM window never touch the RAM and return an error response.
module data_ram_arbiter #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           RAM_SIZE   = 32768,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0010_0000,
    localparam int unsigned          RAM_AW     = $clog2(RAM_SIZE / 4),
    localparam int unsigned          BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                                clk,
    input  logic                                rst,
    // master side
    input  logic [1:0]                          m_req_i,
    input  logic [1:0][ADDR_WIDTH-1:0]          m_addr_i,
    input  logic [1:0]                          m_we_i,
    input  logic [1:0][BE_WIDTH-1:0]            m_be_i,
    input  logic [1:0][DATA_WIDTH-1:0]          m_wdata_i,
    output logic [1:0]                          m_gnt_o,
    output logic [1:0]                          m_rvalid_o,
    output logic [1:0]                          m_err_o,
    output logic [1:0][DATA_WIDTH-1:0]          m_rdata_o,
    // RAM side
    output logic                                ram_en_o,
    output logic [RAM_AW-1:0]                   ram_addr_o,
    output logic                                ram_we_o,
    output logic [BE_WIDTH-1:0]                 ram_be_o,
    output logic [DATA_WIDTH-1:0]               ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]               ram_rdata_i
);

    localparam logic [ADDR_WIDTH-1:0] RamSizeBytes = ADDR_WIDTH'(RAM_SIZE);

    // Round-robin pointer: the master that wins the next tie.
    logic ptr_q, ptr_d;

    // Response pipeline stage, one entry per grant.
    logic rsp_valid_q, rsp_valid_d;
    logic rsp_idx_q,   rsp_idx_d;
    logic rsp_we_q,    rsp_we_d;
    logic rsp_err_q,   rsp_err_d;

    logic [1:0]            gnt;
    logic                  sel;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [ADDR_WIDTH-1:0] sel_offset;
    logic                  sel_in_range;

    // Arbitration: a lone requester always wins, a tie goes to the pointer.
    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            if (m_req_i == 2'b11) begin
                gnt[ptr_q] = 1'b1;
            end else begin
                gnt = m_req_i;
            end
        end
    end

    assign m_gnt_o = gnt;

    // Select master 1 only when it is granted; otherwise master 0 feeds the RAM bus so the
    // don't-care RAM inputs stay quiet when nothing is granted.
    assign sel          = gnt[1];
    assign sel_addr     = m_addr_i[sel];
    assign sel_offset   = sel_addr - BASE_ADDR;
    // Lower bound checked separately so a wrapped subtraction cannot look in range.
    assign sel_in_range = (sel_addr >= BASE_ADDR) && (sel_offset < RamSizeBytes);

    assign ram_en_o    = (|gnt) && sel_in_range;
    assign ram_addr_o  = sel_offset[RAM_AW+1:2];
    assign ram_we_o    = m_we_i[sel];
    assign ram_be_o    = m_be_i[sel];
    assign ram_wdata_o = m_wdata_i[sel];

    // Next state: pointer hands the next tie to the other master; the response stage captures
    // what the granted access needs one cycle later.
    always_comb begin
        ptr_d = ptr_q;
        if (|gnt) begin
            ptr_d = ~sel;
        end
        rsp_valid_d = |gnt;
        rsp_idx_d   = sel;
        rsp_we_d    = m_we_i[sel];
        rsp_err_d   = ~sel_in_range;
    end

    // State registers with synchronous reset; pending responses are dropped on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_idx_q   <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_idx_q   <= rsp_idx_d;
            rsp_we_q    <= rsp_we_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Response steering: only the owning master sees rvalid; rdata is zero unless it carries
    // a successful read. A response pending when reset rises is suppressed immediately.
    always_comb begin
        m_rvalid_o = 2'b00;
        m_err_o    = 2'b00;
        m_rdata_o  = '0;
        if (rsp_valid_q && !rst) begin
            m_rvalid_o[rsp_idx_q] = 1'b1;
            m_err_o[rsp_idx_q]    = rsp_err_q;
            if (!rsp_we_q && !rsp_err_q) begin
                m_rdata_o[rsp_idx_q] = ram_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed bench for data_ram_arbiter with a behavioural single-port RAM attached.
module tb_data_ram_arbiter;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        m_req;
    logic [1:0][31:0]  m_addr;
    logic [1:0]        m_we;
    logic [1:0][3:0]   m_be;
    logic [1:0][31:0]  m_wdata;
    logic [1:0]        m_gnt;
    logic [1:0]        m_rvalid;
    logic [1:0]        m_err;
    logic [1:0][31:0]  m_rdata;
    logic              ram_en;
    logic [12:0]       ram_addr;
    logic              ram_we;
    logic [3:0]        ram_be;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata = 32'h0;

    int n_checks = 0;
    int n_errors = 0;

    data_ram_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .m_req_i     (m_req),
        .m_addr_i    (m_addr),
        .m_we_i      (m_we),
        .m_be_i      (m_be),
        .m_wdata_i   (m_wdata),
        .m_gnt_o     (m_gnt),
        .m_rvalid_o  (m_rvalid),
        .m_err_o     (m_err),
        .m_rdata_o   (m_rdata),
        .ram_en_o    (ram_en),
        .ram_addr_o  (ram_addr),
        .ram_we_o    (ram_we),
        .ram_be_o    (ram_be),
        .ram_wdata_o (ram_wdata),
        .ram_rdata_i (ram_rdata)
    );

    always #5 clk = ~clk;

    // RAM model: 1-cycle read latency, byte-enabled writes, preloaded on the first edge.
    logic [31:0] mem [0:8191];
    logic        mem_init = 1'b0;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 8192; i++) mem[i] <= 32'h0;
            mem[0]        <= 32'hA0A0_A0A0;
            mem[1]        <= 32'hB1B1_B1B1;
            mem[2]        <= 32'hDEAD_BEEF;
            mem[13'h1FFF] <= 32'hAABB_CCDD;
            mem_init      <= 1'b1;
        end else if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
                end
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_g;
        logic [1:0] exp_v;
        rst     = 1'b1;
        m_req   = 2'b00;
        m_addr  = '0;
        m_we    = 2'b00;
        m_be    = {4'hF, 4'hF};
        m_wdata = '0;

        // Reset: requests are ignored while rst is high.
        tick();
        m_req     = 2'b11;
        m_addr[0] = 32'h0010_0000;
        m_addr[1] = 32'h0010_0004;
        #1;
        chk("rst_gnt", 32'(m_gnt), 32'h0);
        chk("rst_ram_en", 32'(ram_en), 32'h0);
        tick();
        rst   = 1'b0;
        m_req = 2'b00;
        #1;
        chk("idle_gnt", 32'(m_gnt), 32'h0);
        chk("idle_ram_en", 32'(ram_en), 32'h0);
        tick();
        chk("idle_rvalid", 32'(m_rvalid), 32'h0);
        chk("idle_err", 32'(m_err), 32'h0);
        chk("idle_rdata0", m_rdata[0], 32'h0);
        chk("idle_rdata1", m_rdata[1], 32'h0);

        // Single read by M0 at word 2.
        tick();
        m_req     = 2'b01;
        m_addr[0] = 32'h0010_0008;
        m_we      = 2'b00;
        #1;
        chk("rd_gnt", 32'(m_gnt), 32'h1);
        chk("rd_ram_en", 32'(ram_en), 32'h1);
        chk("rd_ram_addr", 32'(ram_addr), 32'h2);
        chk("rd_ram_we", 32'(ram_we), 32'h0);
        tick();
        m_req = 2'b00;
        #1;
        chk("rd_rvalid", 32'(m_rvalid), 32'h1);
        chk("rd_rdata0", m_rdata[0], 32'hDEAD_BEEF);
        chk("rd_err", 32'(m_err), 32'h0);
        chk("rd_rdata1", m_rdata[1], 32'h0);

        // Contention straight out of reset: grants alternate starting with M0.
        tick();
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        m_req     = 2'b11;
        m_addr[0] = 32'h0010_0000;
        m_addr[1] = 32'h0010_0004;
        for (int i = 0; i < 6; i++) begin
            #1;
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_v = (i == 0) ? 2'b00 : ((i % 2 == 0) ? 2'b10 : 2'b01);
            chk($sformatf("cont_gnt_%0d", i), 32'(m_gnt), 32'(exp_g));
            chk($sformatf("cont_addr_%0d", i), 32'(ram_addr), 32'(i % 2));
            chk($sformatf("cont_rvalid_%0d", i), 32'(m_rvalid), 32'(exp_v));
            if (i != 0 && i % 2 == 0) chk($sformatf("cont_rdata1_%0d", i), m_rdata[1], 32'hB1B1_B1B1);
            if (i % 2 == 1) chk($sformatf("cont_rdata0_%0d", i), m_rdata[0], 32'hA0A0_A0A0);
            tick();
        end
        m_req = 2'b00;
        #1;
        chk("cont_last_rvalid", 32'(m_rvalid), 32'h2);
        chk("cont_last_rdata1", m_rdata[1], 32'hB1B1_B1B1);

        // M1 writes the top word with two byte lanes, then reads it back.
        tick();
        m_req      = 2'b10;
        m_addr[1]  = 32'h0010_7FFC;
        m_we       = 2'b10;
        m_be[1]    = 4'b0011;
        m_wdata[1] = 32'h1234_5678;
        #1;
        chk("wr_gnt", 32'(m_gnt), 32'h2);
        chk("wr_ram_en", 32'(ram_en), 32'h1);
        chk("wr_ram_addr", 32'(ram_addr), 32'h1FFF);
        chk("wr_ram_we", 32'(ram_we), 32'h1);
        chk("wr_ram_be", 32'(ram_be), 32'h3);
        chk("wr_ram_wdata", ram_wdata, 32'h1234_5678);
        tick();
        m_we = 2'b00;
        #1;
        chk("wr_rvalid", 32'(m_rvalid), 32'h2);
        chk("wr_rdata1", m_rdata[1], 32'h0);
        chk("wr_err", 32'(m_err), 32'h0);
        chk("rb_gnt", 32'(m_gnt), 32'h2);
        chk("rb_ram_we", 32'(ram_we), 32'h0);
        tick();
        m_req = 2'b00;
        #1;
        chk("rb_rvalid", 32'(m_rvalid), 32'h2);
        chk("rb_rdata1", m_rdata[1], 32'hAABB_5678);

        // Out-of-range: one past the top, then one word below the base.
        tick();
        m_req     = 2'b01;
        m_addr[0] = 32'h0010_8000;
        #1;
        chk("oor_hi_gnt", 32'(m_gnt), 32'h1);
        chk("oor_hi_ram_en", 32'(ram_en), 32'h0);
        tick();
        m_addr[0] = 32'h000F_FFFC;
        #1;
        chk("oor_hi_rvalid", 32'(m_rvalid), 32'h1);
        chk("oor_hi_err", 32'(m_err), 32'h1);
        chk("oor_hi_rdata0", m_rdata[0], 32'h0);
        chk("oor_lo_gnt", 32'(m_gnt), 32'h1);
        chk("oor_lo_ram_en", 32'(ram_en), 32'h0);
        tick();
        m_req = 2'b00;
        #1;
        chk("oor_lo_rvalid", 32'(m_rvalid), 32'h1);
        chk("oor_lo_err", 32'(m_err), 32'h1);
        chk("oor_lo_rdata0", m_rdata[0], 32'h0);

        // Reset right after a granted read: response dropped, pointer back to M0.
        tick();
        m_req     = 2'b01;
        m_addr[0] = 32'h0010_0000;
        #1;
        chk("mid_gnt", 32'(m_gnt), 32'h1);
        tick();
        rst   = 1'b1;
        m_req = 2'b00;
        #1;
        chk("mid_rst_rvalid", 32'(m_rvalid), 32'h0);
        chk("mid_rst_rdata0", m_rdata[0], 32'h0);
        tick();
        rst   = 1'b0;
        m_req = 2'b11;
        #1;
        chk("mid_tie_gnt", 32'(m_gnt), 32'h1);
        chk("mid_post_rvalid", 32'(m_rvalid), 32'h0);
        tick();
        m_req = 2'b00;
        #1;
        chk("mid_tie_rvalid", 32'(m_rvalid), 32'h1);
        chk("mid_tie_rdata0", m_rdata[0], 32'hA0A0_A0A0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
